reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, shared write-queue entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 32, writeback data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports mem_valid input 1, mem_dest input 4, mem_data input DATA_W  memory-stage writeback request (older instruction).
REQ-006 SHALL have ports exe_valid input 1, exe_dest input 4, exe_data input DATA_W  execute-stage writeback request (younger instruction).
REQ-007 SHALL have ports mem_ready output 1, exe_ready output 1  per-source accept.
REQ-008 SHALL have ports wb_en output 1, wb_dest output 4, wb_data output DATA_W  registered drive of the register-file write port.
REQ-009 SHALL have ports q_src1 input 4, q_src2 input 4, q_hit1 output 1, q_hit2 output 1  pending-write lookup for hazard logic.
REQ-010 SHALL have port count output log2(DEPTH)+1  current queue occupancy.

Function
REQ-011 SHALL hold one shared circular FIFO of {dest, data}, read pointer, write pointer, occupancy count; pointers wrap modulo DEPTH.
REQ-012 SHALL compute free = DEPTH - count from registered count only (same-cycle dequeue does not add space).
REQ-013 SHALL drive mem_ready = (free >= 1); exe_ready = (free >= 2) when mem_valid, else (free >= 1).
REQ-014 SHALL accept a source on a rising edge when its valid and ready are both high; held valid without ready SHALL not enqueue.
REQ-015 SHALL, when both accepted in one cycle, write mem entry at wptr and exe entry at wptr+1 (program order), advancing wptr by 2.
REQ-016 SHALL dequeue the head each cycle count>0, loading wb_dest/wb_data from head and setting wb_en=1 for the next cycle; wb_en=0 when count=0.
REQ-017 SHALL update count = count + enqueues - dequeue (0..2 in, 0..1 out) in the same edge; simultaneous enqueue and dequeue at full or empty SHALL be exact.
REQ-018 SHALL have minimum latency 2 edges: accept at edge k, wb_en high in cycle after edge k+1; no bypass path.
REQ-019 SHALL retire exactly one entry per cycle; throughput 1 write/cycle, back-to-back without bubbles while count>0.
REQ-020 SHALL assert q_hitN combinationally when any valid queue entry or the wb output register (wb_en=1) has dest == q_srcN.
REQ-021 SHALL leave wb_dest/wb_data holding last values while wb_en=0.
REQ-022 SHALL never overwrite an unretired entry; overflow is impossible by REQ-013 and SHALL be flagged by assertion.

Reset
REQ-023 SHALL, on rst low, asynchronously clear rptr, wptr, count to 0, wb_en to 0, wb_dest to 0, wb_data to 0.
REQ-024 SHALL discard all queued entries on reset mid-operation; no write issues in the cycle after release.
REQ-025 SHALL not reset queue storage arrays.

Structure
REQ-026 SHALL place DEPTH default, register-index width (4) and the {dest,data} entry record in the shared package used by the register file and pipeline.
REQ-027 SHALL instantiate one sub-module, wb_fifo2w1r (2-write 1-read circular buffer); arbitration, ready and lookup logic stay in reg_wb_arbiter.

Verification
REQ-028 SHALL test: single mem write dest=2 data=0x0000_00AA at edge k -> wb_en=1, wb_dest=2, wb_data=0xAA after edge k+1 only, count 1 then 0.
REQ-029 SHALL test: mem(dest=3,0x11) and exe(dest=3,0x22) same cycle -> wb order 0x11 then 0x22 on consecutive cycles.
REQ-030 SHALL test: fill to DEPTH=4 with no drain stall forced by back-to-back pairs -> mem_ready=0 at count=4; exe_ready=0 when count=3 and mem_valid=1; no entry lost.
REQ-031 SHALL test: pointer wrap -> 10 consecutive single writes dest=0..9 retire in order with data intact.
REQ-032 SHALL test: q_src1=5 with dest 5 queued -> q_hit1=1 until the cycle after its wb_en pulse, then 0.
REQ-033 SHALL test: rst low with count=3 mid-stream -> wb_en=0 immediately, count=0, no write after release until new accept.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-writeback definitions used by the register file, the pipeline
// and the writeback arbiter.
package reg_wb_arbiter_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int REG_W     = 4;
  localparam int WB_DATA_W = 32;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t               dest;
    logic [WB_DATA_W-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo2w1r.sv
// Circular buffer of {dest, data} with two write ports (written in port order)
// and one read port presenting the head entry.
module wb_fifo2w1r
  import reg_wb_arbiter_pkg::*;
#(
  parameter int   DEPTH  = WB_DEPTH,
  parameter int   DATA_W = WB_DATA_W,
  localparam int  PW     = $clog2(DEPTH),
  localparam int  CW     = PW + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr0_en,
  input  reg_idx_t                    wr0_dest,
  input  logic [DATA_W-1:0]           wr0_data,
  input  logic                        wr1_en,
  input  reg_idx_t                    wr1_dest,
  input  logic [DATA_W-1:0]           wr1_data,
  input  logic                        rd_en,
  output reg_idx_t                    head_dest,
  output logic [DATA_W-1:0]           head_data,
  output logic [PW-1:0]               rptr,
  output logic [CW-1:0]               count,
  output logic [DEPTH-1:0][REG_W-1:0] dest_vec
);

  reg_idx_t          dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     wr1_ptr;
  logic [CW:0]       fill_after_wr;

  // The second write lands behind the first when both fire in one cycle.
  assign wr1_ptr = wptr + PW'(wr0_en);

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count,
  // so stale contents are never observable and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      dest_mem[wptr] <= wr0_dest;
      data_mem[wptr] <= wr0_data;
    end
    if (wr1_en) begin
      dest_mem[wr1_ptr] <= wr1_dest;
      data_mem[wr1_ptr] <= wr1_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(wr0_en) + PW'(wr1_en);
      rptr  <= rptr + PW'(rd_en);
      count <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    end
  end

  assign head_dest = dest_mem[rptr];
  assign head_data = data_mem[rptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) dest_vec[i] = dest_mem[i];
  end

  assign fill_after_wr = {1'b0, count} + (CW+1)'(wr0_en) + (CW+1)'(wr1_en);

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) fill_after_wr <= (CW+1)'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) rd_en |-> count != '0);

endmodule

// File: rtl/reg_wb_arbiter.sv
// Merges memory- and execute-stage writebacks into one register-file write port
// through a shared queue, retiring one entry per cycle in program order.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int  DEPTH  = WB_DEPTH,
  parameter int  DATA_W = WB_DATA_W,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  reg_idx_t          mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              exe_valid,
  input  reg_idx_t          exe_dest,
  input  logic [DATA_W-1:0] exe_data,
  output logic              mem_ready,
  output logic              exe_ready,
  output logic              wb_en,
  output reg_idx_t          wb_dest,
  output logic [DATA_W-1:0] wb_data,
  input  reg_idx_t          q_src1,
  input  reg_idx_t          q_src2,
  output logic              q_hit1,
  output logic              q_hit2,
  output logic [CW-1:0]     count
);

  logic [CW-1:0]              free;
  logic                       mem_acc;
  logic                       exe_acc;
  logic                       deq;
  reg_idx_t                   head_dest;
  logic [DATA_W-1:0]          head_data;
  logic [PW-1:0]              rptr;
  logic [DEPTH-1:0][REG_W-1:0] dest_vec;
  logic [DEPTH-1:0]           live;

  // Space comes from the registered count only; a same-cycle retire frees nothing.
  assign free      = CW'(DEPTH) - count;
  assign mem_ready = free >= CW'(1);
  assign exe_ready = mem_valid ? (free >= CW'(2)) : (free >= CW'(1));
  assign mem_acc   = mem_valid & mem_ready;
  assign exe_acc   = exe_valid & exe_ready;
  assign deq       = count != '0;

  wb_fifo2w1r #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr0_en    (mem_acc),
    .wr0_dest  (mem_dest),
    .wr0_data  (mem_data),
    .wr1_en    (exe_acc),
    .wr1_dest  (exe_dest),
    .wr1_data  (exe_data),
    .rd_en     (deq),
    .head_dest (head_dest),
    .head_data (head_data),
    .rptr      (rptr),
    .count     (count),
    .dest_vec  (dest_vec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en   <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= deq;
      if (deq) begin
        wb_dest <= head_dest;
        wb_data <= head_data;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) live[i] = {1'b0, PW'(PW'(i) - rptr)} < count;
  end

  // NOTE: both hit flags get a value before the loop, so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    q_hit1 = wb_en && (wb_dest == q_src1);
    q_hit2 = wb_en && (wb_dest == q_src2);
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && dest_vec[i] == q_src1) q_hit1 = 1'b1;
      if (live[i] && dest_vec[i] == q_src2) q_hit2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: latency, ordering, backpressure, wrap,
// hazard lookup and mid-stream reset.
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, exe_valid;
  reg_idx_t    mem_dest, exe_dest;
  logic [31:0] mem_data, exe_data;
  logic        mem_ready, exe_ready;
  logic        wb_en;
  reg_idx_t    wb_dest;
  logic [31:0] wb_data;
  reg_idx_t    q_src1, q_src2;
  logic        q_hit1, q_hit2;
  logic [2:0]  count;

  // Second instance at DEPTH=2 so the full condition is reachable.
  logic        b_mem_valid, b_exe_valid;
  reg_idx_t    b_mem_dest, b_exe_dest;
  logic [31:0] b_mem_data, b_exe_data;
  logic        b_mem_ready, b_exe_ready;
  logic        b_wb_en;
  reg_idx_t    b_wb_dest;
  logic [31:0] b_wb_data;
  reg_idx_t    b_q_src1, b_q_src2;
  logic        b_q_hit1, b_q_hit2;
  logic [1:0]  b_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.DEPTH(4), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
    .exe_valid(exe_valid), .exe_dest(exe_dest), .exe_data(exe_data),
    .mem_ready(mem_ready), .exe_ready(exe_ready),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .q_src1(q_src1), .q_src2(q_src2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .count(count)
  );

  reg_wb_arbiter #(.DEPTH(2), .DATA_W(32)) u_dut2 (
    .clk(clk), .rst(rst),
    .mem_valid(b_mem_valid), .mem_dest(b_mem_dest), .mem_data(b_mem_data),
    .exe_valid(b_exe_valid), .exe_dest(b_exe_dest), .exe_data(b_exe_data),
    .mem_ready(b_mem_ready), .exe_ready(b_exe_ready),
    .wb_en(b_wb_en), .wb_dest(b_wb_dest), .wb_data(b_wb_data),
    .q_src1(b_q_src1), .q_src2(b_q_src2), .q_hit1(b_q_hit1), .q_hit2(b_q_hit2),
    .count(b_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_valid = 0; mem_dest = 0; mem_data = 0;
    exe_valid = 0; exe_dest = 0; exe_data = 0;
    q_src1 = 0; q_src2 = 0;
    b_mem_valid = 0; b_mem_dest = 0; b_mem_data = 0;
    b_exe_valid = 0; b_exe_dest = 0; b_exe_data = 0;
    b_q_src1 = 0; b_q_src2 = 0;
    step(); step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en got=%0b exp=0", wb_en); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if ({wb_dest, wb_data} !== 36'd0) begin n_err++; $display("FAIL reset_wb_regs got=%0h/%0h exp=0/0", wb_dest, wb_data); end
    n_cmp++; if ({mem_ready, exe_ready} !== 2'b11) begin n_err++; $display("FAIL reset_ready got=%b exp=11", {mem_ready, exe_ready}); end
    rst = 1'b1;
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL reset_release_wb_en got=%0b exp=0", wb_en); end
  endtask

  task automatic test_single();
    mem_valid = 1; mem_dest = 2; mem_data = 32'h0000_00AA;
    step();
    mem_valid = 0;
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count_k got=%0d exp=1", count); end
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL single_no_bypass got=%0b exp=0", wb_en); end
    step();
    n_cmp++; if ({wb_en, wb_dest, wb_data} !== {1'b1, 4'd2, 32'hAA}) begin n_err++; $display("FAIL single_wb got=%0b/%0d/%0h exp=1/2/aa", wb_en, wb_dest, wb_data); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count_k1 got=%0d exp=0", count); end
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL single_wb_off got=%0b exp=0", wb_en); end
    n_cmp++; if ({wb_dest, wb_data} !== {4'd2, 32'hAA}) begin n_err++; $display("FAIL single_hold got=%0d/%0h exp=2/aa", wb_dest, wb_data); end
  endtask

  task automatic test_pair_order();
    mem_valid = 1; mem_dest = 3; mem_data = 32'h11;
    exe_valid = 1; exe_dest = 3; exe_data = 32'h22;
    #1;
    n_cmp++; if (exe_ready !== 1'b1) begin n_err++; $display("FAIL pair_exe_ready got=%0b exp=1", exe_ready); end
    step();
    mem_valid = 0; exe_valid = 0;
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL pair_count got=%0d exp=2", count); end
    step();
    n_cmp++; if ({wb_en, wb_data} !== {1'b1, 32'h11}) begin n_err++; $display("FAIL pair_first got=%0b/%0h exp=1/11", wb_en, wb_data); end
    step();
    n_cmp++; if ({wb_en, wb_data} !== {1'b1, 32'h22}) begin n_err++; $display("FAIL pair_second got=%0b/%0h exp=1/22", wb_en, wb_data); end
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL pair_done got=%0b exp=0", wb_en); end
  endtask

  task automatic test_fill();
    mem_valid = 1; mem_dest = 0; mem_data = 32'hA0;
    exe_valid = 1; exe_dest = 1; exe_data = 32'hA1;
    step();
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL fill_count_a got=%0d exp=2", count); end
    mem_dest = 2; mem_data = 32'hA2; exe_dest = 3; exe_data = 32'hA3;
    #1;
    n_cmp++; if (exe_ready !== 1'b1) begin n_err++; $display("FAIL fill_exe_ready_free2 got=%0b exp=1", exe_ready); end
    step();
    n_cmp++; if ({count, wb_en, wb_data} !== {3'd3, 1'b1, 32'hA0}) begin n_err++; $display("FAIL fill_b got=%0d/%0b/%0h exp=3/1/a0", count, wb_en, wb_data); end
    mem_dest = 4; mem_data = 32'hA4; exe_dest = 5; exe_data = 32'hA5;
    #1;
    n_cmp++; if ({mem_ready, exe_ready} !== 2'b10) begin n_err++; $display("FAIL fill_ready_c3 got=%b exp=10", {mem_ready, exe_ready}); end
    step();
    n_cmp++; if ({count, wb_data} !== {3'd3, 32'hA1}) begin n_err++; $display("FAIL fill_c got=%0d/%0h exp=3/a1", count, wb_data); end
    mem_valid = 0;
    #1;
    n_cmp++; if (exe_ready !== 1'b1) begin n_err++; $display("FAIL fill_exe_ready_alone got=%0b exp=1", exe_ready); end
    step();
    exe_valid = 0;
    n_cmp++; if ({count, wb_dest, wb_data} !== {3'd3, 4'd2, 32'hA2}) begin n_err++; $display("FAIL fill_d got=%0d/%0d/%0h exp=3/2/a2", count, wb_dest, wb_data); end
    step();
    for (int k = 3; k <= 5; k++) begin
      n_cmp++;
      if ({wb_en, wb_dest, wb_data, count} !== {1'b1, 4'(k), 32'hA0 + 32'(k), 3'(5 - k)}) begin
        n_err++; $display("FAIL fill_drain_%0d got=%0b/%0d/%0h/%0d exp=1/%0d/%0h/%0d", k, wb_en, wb_dest, wb_data, count, k, 32'hA0 + k, 5 - k);
      end
      step();
    end
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL fill_done got=%0b exp=0", wb_en); end
  endtask

  task automatic test_wrap();
    for (int c = 0; c <= 12; c++) begin
      mem_valid = (c < 10); mem_dest = 4'(c); mem_data = 32'h1000 + 32'(c);
      if (c >= 1 && c <= 10) begin
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL wrap_count_%0d got=%0d exp=1", c, count); end
      end
      if (c >= 2 && c <= 11) begin
        n_cmp++;
        if ({wb_en, wb_dest, wb_data} !== {1'b1, 4'(c - 2), 32'h1000 + 32'(c - 2)}) begin
          n_err++; $display("FAIL wrap_wb_%0d got=%0b/%0d/%0h exp=1/%0d/%0h", c, wb_en, wb_dest, wb_data, c - 2, 32'h1000 + c - 2);
        end
      end
      if (c == 12) begin
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL wrap_done got=%0b exp=0", wb_en); end
      end
      step();
    end
  endtask

  task automatic test_hit();
    q_src1 = 5; q_src2 = 7;
    #1;
    n_cmp++; if ({q_hit1, q_hit2} !== 2'b00) begin n_err++; $display("FAIL hit_stale got=%b exp=00", {q_hit1, q_hit2}); end
    q_src2 = 6;
    mem_valid = 1; mem_dest = 5; mem_data = 32'h55;
    exe_valid = 1; exe_dest = 6; exe_data = 32'h66;
    #1;
    n_cmp++; if ({q_hit1, q_hit2} !== 2'b00) begin n_err++; $display("FAIL hit_before_accept got=%b exp=00", {q_hit1, q_hit2}); end
    step();
    mem_valid = 0; exe_valid = 0;
    n_cmp++; if ({q_hit1, q_hit2} !== 2'b11) begin n_err++; $display("FAIL hit_queued got=%b exp=11", {q_hit1, q_hit2}); end
    step();
    n_cmp++; if ({wb_en, wb_dest, q_hit1, q_hit2} !== {1'b1, 4'd5, 2'b11}) begin n_err++; $display("FAIL hit_wb5 got=%b/%0d/%b exp=1/5/11", wb_en, wb_dest, {q_hit1, q_hit2}); end
    step();
    n_cmp++; if ({wb_en, wb_dest, q_hit1, q_hit2} !== {1'b1, 4'd6, 2'b01}) begin n_err++; $display("FAIL hit_wb6 got=%b/%0d/%b exp=1/6/01", wb_en, wb_dest, {q_hit1, q_hit2}); end
    step();
    n_cmp++; if ({wb_en, q_hit1, q_hit2} !== 3'b000) begin n_err++; $display("FAIL hit_clear got=%b exp=000", {wb_en, q_hit1, q_hit2}); end
    q_src1 = 0; q_src2 = 0;
  endtask

  task automatic test_full_depth2();
    b_mem_valid = 1; b_mem_dest = 1; b_mem_data = 32'hB1;
    b_exe_valid = 1; b_exe_dest = 2; b_exe_data = 32'hB2;
    step();
    b_exe_valid = 0; b_mem_dest = 3; b_mem_data = 32'hB3;
    #1;
    n_cmp++; if ({b_count, b_mem_ready, b_exe_ready} !== {2'd2, 2'b00}) begin n_err++; $display("FAIL full_ready got=%0d/%b exp=2/00", b_count, {b_mem_ready, b_exe_ready}); end
    step();
    b_mem_valid = 0;
    n_cmp++; if ({b_count, b_wb_en, b_wb_data} !== {2'd1, 1'b1, 32'hB1}) begin n_err++; $display("FAIL full_held got=%0d/%0b/%0h exp=1/1/b1", b_count, b_wb_en, b_wb_data); end
    step();
    n_cmp++; if ({b_count, b_wb_en, b_wb_data} !== {2'd0, 1'b1, 32'hB2}) begin n_err++; $display("FAIL full_second got=%0d/%0b/%0h exp=0/1/b2", b_count, b_wb_en, b_wb_data); end
    step();
    n_cmp++; if (b_wb_en !== 1'b0) begin n_err++; $display("FAIL full_no_extra got=%0b exp=0", b_wb_en); end
  endtask

  task automatic test_reset_mid();
    mem_valid = 1; mem_dest = 8; mem_data = 32'hC0;
    exe_valid = 1; exe_dest = 9; exe_data = 32'hC1;
    step(); step();
    mem_valid = 0; exe_valid = 0;
    n_cmp++; if ({count, wb_en} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL rmid_setup got=%0d/%0b exp=3/1", count, wb_en); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({count, wb_en, wb_data} !== {3'd0, 1'b0, 32'h0}) begin n_err++; $display("FAIL rmid_async got=%0d/%0b/%0h exp=0/0/0", count, wb_en, wb_data); end
    step();
    rst = 1'b1;
    step();
    n_cmp++; if ({count, wb_en} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL rmid_release got=%0d/%0b exp=0/0", count, wb_en); end
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL rmid_quiet got=%0b exp=0", wb_en); end
    mem_valid = 1; mem_dest = 9; mem_data = 32'h99;
    step();
    mem_valid = 0;
    step();
    n_cmp++; if ({wb_en, wb_dest, wb_data} !== {1'b1, 4'd9, 32'h99}) begin n_err++; $display("FAIL rmid_new got=%0b/%0d/%0h exp=1/9/99", wb_en, wb_dest, wb_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair_order();
    test_fill();
    test_wrap();
    test_hit();
    test_full_depth2();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
